avmm_local_mem_responder: RTL and testbench
===========================================

Name: avmm_local_mem_responder

Overview:
- Avalon-MM sink that terminates one local-memory bank port. It is the responder end of the burst interface the local-memory test engines drive.
- Used in simulation and in loopback builds to stand in for an EMIF bank. A test engine can then exercise read/write bursts, byteenables, waitrequest back-pressure and readdatavalid timing without a physical memory controller.
- Contains a small on-chip word array, a read-command FIFO, a write-burst state machine and a fixed-latency read pipeline.

Parameters:
ADDR_WIDTH, 10, word address width; array depth is 2**ADDR_WIDTH words.
DATA_WIDTH, 512, data bits per word; must be a multiple of 8.
BURST_CNT_WIDTH, 7, burstcount width; legal burstcount is 1..2**(BURST_CNT_WIDTH-1).
READ_LATENCY, 2, cycles from read-beat issue to readdatavalid; minimum 1.
CMD_FIFO_DEPTH, 4, number of queued read commands; must be a power of 2 and at least 2.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
waitrequest  out  1  command/beat not accepted this cycle
read  in  1  read command
write  in  1  write beat
address  in  ADDR_WIDTH  word address, sampled on a command's first beat
burstcount  in  BURST_CNT_WIDTH  beats in the burst, sampled on the first beat
writedata  in  DATA_WIDTH  write data
byteenable  in  DATA_WIDTH/8  per-byte write enable
readdata  out  DATA_WIDTH  read data
readdatavalid  out  1  readdata is valid
response  out  2  always 2'b00
rd_beat_cnt  out  32  read beats returned, wraps modulo 2**32
wr_beat_cnt  out  32  write beats accepted, wraps modulo 2**32
proto_error  out  1  sticky protocol-violation flag

Behaviour:
- Reset asynchronously clears:
  - waitrequest=1; readdatavalid=0; readdata=0; counters=0; proto_error=0.
  - The command FIFO, write FSM and read pipeline are emptied.
  - Array contents are retained, not cleared.
- waitrequest deasserts in the first clock edge after reset is released. After that, waitrequest = cmd FIFO full.
- Acceptance:
  - A read is accepted when read=1 and waitrequest=0.
  - A write beat is accepted when write=1 and waitrequest=0.
- Write FSM states WR_IDLE and WR_BURST:
  - In WR_IDLE, an accepted write latches address and burstcount. Data is written to address[ADDR_WIDTH-1:0] with byteenable masking in the same edge.
  - If burstcount>1, the FSM moves to WR_BURST with remaining=burstcount-1 and next address = address+1.
  - In WR_BURST, address and burstcount are ignored. Each accepted beat writes to the next address and decrements remaining. The FSM returns to WR_IDLE when the last beat is accepted.
- Read commands: an accepted read pushes {address, burstcount} into the FIFO.
- Read engine:
  - It pops the FIFO head and issues one beat per cycle, with address incrementing by 1.
  - Beat N of a command is issued in cycle N after the pop. The first beat issues on the cycle after the command is accepted if the engine is idle.
  - Back-to-back commands issue with no bubble between them.
  - A beat issued in cycle C produces readdatavalid=1 with that word at C+READ_LATENCY.
  - The engine never stalls: there is no readdata back-pressure.
- Array port contention:
  - The array has one write port and one read port.
  - On a same-address write and read issue in the same cycle, the read returns the OLD data.
  - A read command accepted in a cycle after a write beat is accepted always observes the new data.
- Address arithmetic: burst addresses wrap modulo 2**ADDR_WIDTH, so the word after address 2**ADDR_WIDTH-1 is address 0.
- Protocol violations set proto_error. It stays set until reset. Each violation is handled as follows:
  - burstcount=0 on a first beat: treated as 1.
  - read and write asserted together and accepted: the write is performed and the read is dropped.
  - read accepted while in WR_BURST: the read is dropped.
  - burstcount larger than 2**(BURST_CNT_WIDTH-1): executed as given.
- Counters:
  - wr_beat_cnt increments on each accepted write beat.
  - rd_beat_cnt increments on each cycle readdatavalid=1.
- Reset during operation: in-flight beats are discarded, readdatavalid drops asynchronously, and there are no partial writes beyond beats already accepted.

Test Plan:
- Write burst then read: write burstcount=4 at address 0x10, data 0xA0..0xA3, byteenable all-ones; then read burstcount=4 at 0x10, accepted in cycle T -> readdatavalid at T+1+2 through T+4+2 carrying 0xA0..0xA3; wr_beat_cnt=4, rd_beat_cnt=4.
- Byteenable masking: fill 0x20 with all-ones, write 0 with byteenable=...0001 -> readback has byte0=0x00 and all other bytes 0xFF.
- Address wrap: write burstcount=3 at 0x3FE (ADDR_WIDTH=10) -> words 0x3FE, 0x3FF, 0x000 are written; read burstcount=3 at 0x3FE returns them in that order.
- FIFO back-pressure: issue 6 single-beat reads on consecutive cycles with burstcount=8 -> waitrequest rises after 4 queued commands; all 48 beats return contiguously; rd_beat_cnt=48.
- Protocol errors: read=write=1 in WR_IDLE -> write performed, no readdatavalid, proto_error=1. Separately, burstcount=0 read -> exactly 1 beat returned and proto_error=1.
- Reset mid-read-burst: assert reset during the 3rd beat of an 8-beat read -> readdatavalid=0 immediately, waitrequest=1 during reset; after release, a readback of previously written data is unchanged and the counters are 0.

Source files
------------

// File: rtl/avmm_local_mem_responder.sv
// Avalon-MM burst responder backed by an on-chip word array: stands in for an
// EMIF bank with a queued, fixed-latency read path and a byte-masked write FSM.
module avmm_local_mem_responder #(
    parameter int ADDR_WIDTH      = 10,
    parameter int DATA_WIDTH      = 512,
    parameter int BURST_CNT_WIDTH = 7,
    parameter int READ_LATENCY    = 2,
    parameter int CMD_FIFO_DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic                       waitrequest,
    input  logic                       read,
    input  logic                       write,
    input  logic [ADDR_WIDTH-1:0]      address,
    input  logic [BURST_CNT_WIDTH-1:0] burstcount,
    input  logic [DATA_WIDTH-1:0]      writedata,
    input  logic [DATA_WIDTH/8-1:0]    byteenable,
    output logic [DATA_WIDTH-1:0]      readdata,
    output logic                       readdatavalid,
    output logic [1:0]                 response,
    output logic [31:0]                rd_beat_cnt,
    output logic [31:0]                wr_beat_cnt,
    output logic                       proto_error
);
    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int PTR_W = $clog2(CMD_FIFO_DEPTH);
    localparam logic [BURST_CNT_WIDTH-1:0] BC_MAX = BURST_CNT_WIDTH'(2 ** (BURST_CNT_WIDTH - 1));
    localparam logic [BURST_CNT_WIDTH-1:0] BC_ONE = BURST_CNT_WIDTH'(1);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0]      addr;
        logic [BURST_CNT_WIDTH-1:0] bc;
    } rd_cmd_t;

    typedef enum logic { WR_IDLE, WR_BURST } wr_state_t;

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    logic                       up;
    rd_cmd_t                    fifo [CMD_FIFO_DEPTH];
    logic [PTR_W-1:0]           wp, rp;
    logic [PTR_W:0]             cnt;
    logic                       full;

    wr_state_t                  wr_st;
    logic [ADDR_WIDTH-1:0]      wr_addr;
    logic [BURST_CNT_WIDTH-1:0] wr_rem;

    logic                       rd_busy;
    logic [ADDR_WIDTH-1:0]      rd_addr;
    logic [BURST_CNT_WIDTH-1:0] rd_rem;

    logic [READ_LATENCY:1]      vld_pipe;
    logic [DATA_WIDTH-1:0]      dpipe [1:READ_LATENCY];

    logic                       wr_acc, wr_first, rd_acc, bad_bc, rd_drop;
    logic [BURST_CNT_WIDTH-1:0] wr_bc, head_bc;
    logic [ADDR_WIDTH-1:0]      wr_addr_now, iss_addr;
    rd_cmd_t                    head;
    logic                       issue_pop, issue;

    assign full        = (cnt == (PTR_W+1)'(CMD_FIFO_DEPTH));
    assign waitrequest = !up || full;
    assign response    = 2'b00;

    // A read colliding with a write, or arriving mid write-burst, is dropped.
    assign wr_acc      = write && !waitrequest;
    assign wr_first    = wr_acc && (wr_st == WR_IDLE);
    assign rd_acc      = read && !waitrequest && !write && (wr_st == WR_IDLE);
    assign rd_drop     = read && !waitrequest && (write || wr_st == WR_BURST);
    assign bad_bc      = (burstcount == '0) || (burstcount > BC_MAX);
    assign wr_bc       = (burstcount == '0) ? BC_ONE : burstcount;
    assign wr_addr_now = wr_first ? address : wr_addr;

    assign head        = fifo[rp];
    assign head_bc     = (head.bc == '0) ? BC_ONE : head.bc;
    assign issue_pop   = !rd_busy && (cnt != '0);
    assign issue       = rd_busy || issue_pop;
    assign iss_addr    = rd_busy ? rd_addr : head.addr;

    assign readdatavalid = vld_pipe[READ_LATENCY];
    assign readdata      = dpipe[READ_LATENCY];

    // Array and queue storage carry no reset; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_acc)
            for (int b = 0; b < BE_W; b++)
                if (byteenable[b]) mem[wr_addr_now][b*8 +: 8] <= writedata[b*8 +: 8];
        if (rd_acc)
            fifo[wp] <= '{addr: address, bc: burstcount};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            up          <= 1'b0;
            wp          <= '0;
            rp          <= '0;
            cnt         <= '0;
            wr_st       <= WR_IDLE;
            wr_addr     <= '0;
            wr_rem      <= '0;
            rd_busy     <= 1'b0;
            rd_addr     <= '0;
            rd_rem      <= '0;
            vld_pipe    <= '0;
            for (int k = 1; k <= READ_LATENCY; k++) dpipe[k] <= '0;
            rd_beat_cnt <= '0;
            wr_beat_cnt <= '0;
            proto_error <= 1'b0;
        end else begin
            up <= 1'b1;

            if (rd_acc) wp <= wp + 1'b1;
            if (issue_pop) rp <= rp + 1'b1;
            if (rd_acc && !issue_pop)      cnt <= cnt + 1'b1;
            else if (!rd_acc && issue_pop) cnt <= cnt - 1'b1;

            // The head command's first beat issues straight from the queue, so
            // consecutive commands stream with no idle cycle between them.
            if (rd_busy) begin
                rd_addr <= rd_addr + 1'b1;
                rd_rem  <= rd_rem - 1'b1;
                if (rd_rem == BC_ONE) rd_busy <= 1'b0;
            end else if (issue_pop && head_bc > BC_ONE) begin
                rd_busy <= 1'b1;
                rd_addr <= head.addr + 1'b1;
                rd_rem  <= head_bc - 1'b1;
            end

            case (wr_st)
                WR_IDLE:
                    if (wr_acc && wr_bc > BC_ONE) begin
                        wr_st   <= WR_BURST;
                        wr_rem  <= wr_bc - 1'b1;
                        wr_addr <= address + 1'b1;
                    end
                WR_BURST:
                    if (wr_acc) begin
                        wr_addr <= wr_addr + 1'b1;
                        wr_rem  <= wr_rem - 1'b1;
                        if (wr_rem == BC_ONE) wr_st <= WR_IDLE;
                    end
                default: wr_st <= WR_IDLE;
            endcase

            vld_pipe[1] <= issue;
            dpipe[1]    <= mem[iss_addr];
            for (int k = 2; k <= READ_LATENCY; k++) begin
                vld_pipe[k] <= vld_pipe[k-1];
                dpipe[k]    <= dpipe[k-1];
            end

            if (wr_acc)        wr_beat_cnt <= wr_beat_cnt + 1'b1;
            if (readdatavalid) rd_beat_cnt <= rd_beat_cnt + 1'b1;
            if (((wr_first || rd_acc) && bad_bc) || rd_drop) proto_error <= 1'b1;
        end
    end
endmodule

// File: tb/tb_avmm_local_mem_responder.sv
// Directed bench for avmm_local_mem_responder: vector table for single-word
// byteenable cases plus hand sequences for bursts, back-pressure and reset.
module tb_avmm_local_mem_responder;
    localparam int AW = 10, DW = 512, BW = 7, BEW = DW / 8;

    logic          clk = 1'b0, reset = 1'b1, read = 1'b0, write = 1'b0;
    logic [AW-1:0] address = '0;
    logic [BW-1:0] burstcount = BW'(1);
    logic [DW-1:0] writedata = '0;
    logic [BEW-1:0] byteenable = '1;
    logic          waitrequest, readdatavalid, proto_error;
    logic [DW-1:0] readdata;
    logic [1:0]    response;
    logic [31:0]   rd_beat_cnt, wr_beat_cnt;

    avmm_local_mem_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_CNT_WIDTH(BW),
                               .READ_LATENCY(2), .CMD_FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .waitrequest(waitrequest), .read(read), .write(write),
        .address(address), .burstcount(burstcount), .writedata(writedata),
        .byteenable(byteenable), .readdata(readdata), .readdatavalid(readdatavalid),
        .response(response), .rd_beat_cnt(rd_beat_cnt), .wr_beat_cnt(wr_beat_cnt),
        .proto_error(proto_error));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    logic [DW-1:0] rq[$];
    int            rc[$];
    always @(negedge clk) if (readdatavalid === 1'b1) begin
        rq.push_back(readdata);
        rc.push_back(cyc);
    end

    int checks = 0, errors = 0, exp_wr = 0, exp_rd = 0, acc_cyc = 0, first_acc = 0;
    bit saw_wait = 0;
    logic [DW-1:0] wd [16];
    logic [DW-1:0] ex [16];

    typedef struct {
        bit             wr;
        logic [AW-1:0]  a;
        logic [DW-1:0]  d;   // write data, or expected readback for a read
        logic [BEW-1:0] be;
    } vec_t;
    vec_t vt [8];

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wait_ready(input string nm);
        int t = 0;
        while (waitrequest !== 1'b0 && t < 200) begin
            saw_wait = 1;
            tick();
            t++;
        end
        if (t >= 200) begin
            checks++; errors++;
            $display("FAIL %s waitrequest stuck high", nm);
        end
    endtask

    task automatic wr_burst(input logic [AW-1:0] a, input int n, input logic [BEW-1:0] be);
        for (int i = 0; i < n; i++) begin
            write = 1'b1; address = a; burstcount = BW'(n);
            writedata = wd[i]; byteenable = be;
            wait_ready("wr_accept");
            tick();
        end
        write = 1'b0;
        exp_wr += n;
    endtask

    task automatic rd_cmd(input logic [AW-1:0] a, input logic [BW-1:0] bc);
        read = 1'b1; address = a; burstcount = bc;
        wait_ready("rd_accept");
        acc_cyc = cyc;
        tick();
        read = 1'b0;
    endtask

    task automatic wait_beats(input string nm, input int n);
        int t = 0;
        while (rq.size() < n && t < 300) begin tick(); t++; end
        if (rq.size() < n) begin
            checks++; errors++;
            $display("FAIL %s beats got=%0d want=%0d", nm, rq.size(), n);
        end
    endtask

    task automatic rd_expect(input string nm, input logic [AW-1:0] a, input int n);
        rq.delete(); rc.delete();
        rd_cmd(a, BW'(n));
        wait_beats(nm, n);
        repeat (4) tick();
        chk({nm, "_count"}, DW'(rq.size()), DW'(n));
        exp_rd += rq.size();
        if (rq.size() >= n) begin
            for (int i = 0; i < n; i++) chk($sformatf("%s_d%0d", nm, i), rq[i], ex[i]);
            chk({nm, "_lat"}, DW'(rc[0]), DW'(acc_cyc + 3));
            chk({nm, "_contig"}, DW'(rc[n-1] - rc[0]), DW'(n - 1));
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; tick(); tick();
        reset = 1'b0; tick();
        exp_wr = 0; exp_rd = 0;
    endtask

    initial begin
        vt[0] = '{1'b1, 10'h020, {DW{1'b1}}, {BEW{1'b1}}};
        vt[1] = '{1'b1, 10'h020, {DW{1'b0}}, BEW'(1)};
        vt[2] = '{1'b0, 10'h020, {{(BEW-1){8'hFF}}, 8'h00}, '0};
        vt[3] = '{1'b1, 10'h021, DW'(64'h1234_5678), {BEW{1'b1}}};
        vt[4] = '{1'b1, 10'h021, DW'(64'hFFFF_FFFF), BEW'(2)};
        vt[5] = '{1'b0, 10'h021, DW'(64'h1234_FF78), '0};
        vt[6] = '{1'b1, 10'h022, DW'(8'hAB), {BEW{1'b1}}};
        vt[7] = '{1'b1, 10'h022, {DW{1'b0}}, {BEW{1'b0}}};

        // Reset state
        repeat (3) tick();
        chk("rst_wait", DW'(waitrequest), DW'(1));
        chk("rst_rdv", DW'(readdatavalid), DW'(0));
        chk("rst_rdata", readdata, '0);
        chk("rst_rdcnt", DW'(rd_beat_cnt), '0);
        chk("rst_wrcnt", DW'(wr_beat_cnt), '0);
        chk("rst_perr", DW'(proto_error), '0);
        reset = 1'b0; #1;
        chk("rel_wait_hi", DW'(waitrequest), DW'(1));
        tick();
        chk("rel_wait_lo", DW'(waitrequest), DW'(0));
        chk("rsp", DW'(response), '0);

        // Write burst then read burst
        for (int i = 0; i < 4; i++) begin wd[i] = DW'(8'hA0 + i); ex[i] = wd[i]; end
        wr_burst(10'h010, 4, '1);
        rd_expect("burst", 10'h010, 4);
        chk("burst_wrcnt", DW'(wr_beat_cnt), DW'(4));
        chk("burst_rdcnt", DW'(rd_beat_cnt), DW'(4));

        // Single-word byteenable vectors
        for (int i = 0; i < 8; i++) begin
            if (vt[i].wr) begin
                wd[0] = vt[i].d;
                wr_burst(vt[i].a, 1, vt[i].be);
            end else begin
                ex[0] = vt[i].d;
                rd_expect($sformatf("vec%0d", i), vt[i].a, 1);
            end
        end
        ex[0] = DW'(8'hAB);
        rd_expect("be_none", 10'h022, 1);

        // Address wrap
        for (int i = 0; i < 3; i++) begin wd[i] = DW'(8'hC0 + i); ex[i] = wd[i]; end
        wr_burst(10'h3FE, 3, '1);
        rd_expect("wrap", 10'h3FE, 3);
        ex[0] = DW'(8'hC2);
        rd_expect("wrap0", 10'h000, 1);
        chk("cnt_wr_mid", DW'(wr_beat_cnt), DW'(exp_wr));
        chk("cnt_rd_mid", DW'(rd_beat_cnt), DW'(exp_rd));

        // Queue back-pressure: six 8-beat reads
        rq.delete(); rc.delete(); saw_wait = 0;
        for (int i = 0; i < 6; i++) begin
            rd_cmd(10'h010, BW'(8));
            if (i == 0) first_acc = acc_cyc;
        end
        wait_beats("bp", 48);
        repeat (4) tick();
        exp_rd += 48;
        chk("bp_count", DW'(rq.size()), DW'(48));
        chk("bp_saw_wait", DW'(saw_wait), DW'(1));
        if (rq.size() >= 48) begin
            chk("bp_lat", DW'(rc[0]), DW'(first_acc + 3));
            chk("bp_contig", DW'(rc[47] - rc[0]), DW'(47));
            chk("bp_d0", rq[0], DW'(8'hA0));
            chk("bp_d10", rq[10], DW'(8'hA2));
        end
        chk("bp_rdcnt", DW'(rd_beat_cnt), DW'(exp_rd));
        chk("bp_perr", DW'(proto_error), '0);

        // Read during a write burst is dropped
        rq.delete();
        write = 1'b1; address = 10'h050; burstcount = BW'(2);
        writedata = DW'(8'h77); byteenable = '1;
        wait_ready("wb0"); tick();
        write = 1'b0; read = 1'b1; address = 10'h050;
        wait_ready("wb_rd"); tick();
        read = 1'b0; write = 1'b1; address = 10'h3FF; writedata = DW'(8'h78);
        wait_ready("wb1"); tick();
        write = 1'b0; exp_wr += 2;
        repeat (6) tick();
        chk("wb_drop", DW'(rq.size()), '0);
        chk("wb_perr", DW'(proto_error), DW'(1));
        ex[0] = DW'(8'h77); ex[1] = DW'(8'h78);
        rd_expect("wb_rd", 10'h050, 2);

        // read+write together: write wins, read dropped
        do_reset();
        chk("rw_perr0", DW'(proto_error), '0);
        rq.delete();
        read = 1'b1; write = 1'b1; address = 10'h040; burstcount = BW'(1);
        writedata = DW'(8'h55); byteenable = '1;
        wait_ready("rw"); tick();
        read = 1'b0; write = 1'b0; exp_wr++;
        repeat (6) tick();
        chk("rw_norv", DW'(rq.size()), '0);
        chk("rw_perr", DW'(proto_error), DW'(1));
        ex[0] = DW'(8'h55);
        rd_expect("rw_rd", 10'h040, 1);

        // burstcount=0 read returns one beat
        do_reset();
        rq.delete();
        rd_cmd(10'h040, '0);
        wait_beats("bc0", 1);
        repeat (6) tick();
        exp_rd += rq.size();
        chk("bc0_count", DW'(rq.size()), DW'(1));
        if (rq.size() >= 1) chk("bc0_data", rq[0], DW'(8'h55));
        chk("bc0_perr", DW'(proto_error), DW'(1));
        chk("bc0_rdcnt", DW'(rd_beat_cnt), DW'(exp_rd));

        // Reset during the third beat of an 8-beat read
        do_reset();
        for (int i = 0; i < 8; i++) begin wd[i] = DW'(8'hD0 + i); ex[i] = wd[i]; end
        wr_burst(10'h060, 8, '1);
        rq.delete();
        rd_cmd(10'h060, BW'(8));
        begin
            int t = 0;
            while (!(rq.size() == 2 && readdatavalid === 1'b1) && t < 50) begin tick(); t++; end
            chk("mid_reach", DW'(t < 50), DW'(1));
        end
        reset = 1'b1; #1;
        chk("mid_rdv", DW'(readdatavalid), '0);
        chk("mid_wait", DW'(waitrequest), DW'(1));
        chk("mid_rdata", readdata, '0);
        tick(); tick();
        chk("mid_wait2", DW'(waitrequest), DW'(1));
        reset = 1'b0; tick();
        exp_wr = 0; exp_rd = 0;
        chk("mid_rdcnt0", DW'(rd_beat_cnt), '0);
        chk("mid_wrcnt0", DW'(wr_beat_cnt), '0);
        chk("mid_partial", DW'(rq.size()), DW'(2));
        rd_expect("post_rst", 10'h060, 8);
        chk("post_rdcnt", DW'(rd_beat_cnt), DW'(8));
        chk("post_wrcnt", DW'(wr_beat_cnt), '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
